// File: rtl/mil_bus_hub_pkg.sv
// mil_bus_hub_pkg: shared types and constants for the MIL-STD-1553 line hub.
package mil_bus_hub_pkg;

  // Per-port babble guard states
  typedef enum logic [1:0] {
    GUARD_IDLE     = 2'd0,
    GUARD_TX       = 2'd1,
    GUARD_ISOLATED = 2'd2
  } guard_state_e;

  // One 1553 word is 20 bit times; clk runs at MIL_BIT_CLKS per bit time
  localparam int unsigned MIL_BIT_CLKS    = 60;
  localparam int unsigned MIL_WORD_CYCLES = 20 * MIL_BIT_CLKS;
  localparam int unsigned BABBLE_MAX_DEF  = MIL_WORD_CYCLES;
  localparam int unsigned IDLE_REL_DEF    = 64;

  // Width of a counter that must hold values 0..max_val without wrapping
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mil_bus_hub_guard.sv
// mil_bus_hub_guard: per-port babble guard. Isolates a transmitter that stays
// active for BABBLE_MAX cycles; releases after IDLE_REL quiet cycles or on
// babble_clr. port_en low forces the guard back to idle.
module mil_bus_hub_guard
  import mil_bus_hub_pkg::*;
#(
  parameter int unsigned BABBLE_MAX = BABBLE_MAX_DEF,
  parameter int unsigned IDLE_REL   = IDLE_REL_DEF
) (
  input  logic clk,
  input  logic nRst,
  input  logic tx_p,
  input  logic tx_n,
  input  logic port_en,
  input  logic babble_clr,
  output logic isolated,
  output logic active
);

  localparam int unsigned ACT_W = cnt_w(BABBLE_MAX);
  localparam int unsigned IDL_W = cnt_w(IDLE_REL);
  localparam logic [ACT_W-1:0] ACT_LIMIT = ACT_W'(BABBLE_MAX);
  localparam logic [IDL_W-1:0] IDL_LIMIT = IDL_W'(IDLE_REL);

  guard_state_e     state_q, state_d;
  logic [ACT_W-1:0] act_cnt_q, act_cnt_d, act_inc;
  logic [IDL_W-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
  logic             line_busy;

  assign line_busy = tx_p | tx_n;
  assign isolated  = (state_q == GUARD_ISOLATED);
  assign active    = line_busy & port_en & ~isolated;

  // Guard state and counter registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= GUARD_IDLE;
      act_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      act_cnt_q  <= act_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Next-state and counter logic; the active count is compared after the
  // increment so isolation shows on the cycle after the BABBLE_MAX-th active one
  always_comb begin
    state_d    = state_q;
    act_cnt_d  = act_cnt_q;
    idle_cnt_d = idle_cnt_q;
    act_inc    = '0;
    idle_inc   = '0;
    if (!port_en) begin
      state_d    = GUARD_IDLE;
      act_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        GUARD_IDLE, GUARD_TX: begin
          idle_cnt_d = '0;
          if (active) begin
            act_inc = (state_q == GUARD_IDLE) ? ACT_W'(1) : act_cnt_q + ACT_W'(1);
            if (act_inc == ACT_LIMIT) begin
              state_d   = GUARD_ISOLATED;
              act_cnt_d = '0;
            end else begin
              state_d   = GUARD_TX;
              act_cnt_d = act_inc;
            end
          end else begin
            state_d   = GUARD_IDLE;
            act_cnt_d = '0;
          end
        end
        GUARD_ISOLATED: begin
          act_cnt_d = '0;
          if (babble_clr) begin
            state_d    = GUARD_IDLE;
            idle_cnt_d = '0;
          end else if (!line_busy) begin
            idle_inc = idle_cnt_q + IDL_W'(1);
            if (idle_inc == IDL_LIMIT) begin
              state_d    = GUARD_IDLE;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_inc;
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
        default: begin
          state_d    = GUARD_IDLE;
          act_cnt_d  = '0;
          idle_cnt_d = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mil_bus_hub.sv
// mil_bus_hub: N-port MIL-STD-1553 wired-OR line hub with propagation delay,
// collision detection/counting and per-port babble isolation.
// Optional: define MIL_BUS_HUB_FAULT_INJECT_EN to add faultEn/faultSwap, which
// swap rxP/rxN for one cycle per faultSwap pulse.
module mil_bus_hub
  import mil_bus_hub_pkg::*;
#(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DELAY      = 2,
  parameter int unsigned BABBLE_MAX = BABBLE_MAX_DEF,
  parameter int unsigned IDLE_REL   = IDLE_REL_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [PORTS-1:0] txP,
  input  logic [PORTS-1:0] txN,
  input  logic [PORTS-1:0] portEn,
  input  logic [PORTS-1:0] babbleClr,
`ifdef MIL_BUS_HUB_FAULT_INJECT_EN
  input  logic             faultEn,
  input  logic             faultSwap,
`endif
  output logic [PORTS-1:0] rxP,
  output logic [PORTS-1:0] rxN,
  output logic [PORTS-1:0] babble,
  output logic             collision,
  output logic [CNT_W-1:0] collCnt
);

  logic [PORTS-1:0] port_active;
  logic             bus_p, bus_n, coll_cond, seen_one, multi;
  logic [DELAY-1:0] pipe_p_q, pipe_p_d, pipe_n_q, pipe_n_d;
  logic             coll_cond_q, coll_cond_d, collision_q, collision_d;
  logic [CNT_W-1:0] coll_cnt_q, coll_cnt_d;
  logic             rx_bit_p, rx_bit_n;

  for (genvar g = 0; g < PORTS; g++) begin : g_guard
    mil_bus_hub_guard #(
      .BABBLE_MAX (BABBLE_MAX),
      .IDLE_REL   (IDLE_REL)
    ) u_guard (
      .clk        (clk),
      .nRst       (nRst),
      .tx_p       (txP[g]),
      .tx_n       (txN[g]),
      .port_en    (portEn[g]),
      .babble_clr (babbleClr[g]),
      .isolated   (babble[g]),
      .active     (port_active[g])
    );
  end

  // Wired-OR of active transmitters and collision condition
  always_comb begin
    bus_p    = |(txP & port_active);
    bus_n    = |(txN & port_active);
    seen_one = 1'b0;
    multi    = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (port_active[i]) begin
        multi    = multi | seen_one;
        seen_one = 1'b1;
      end
    end
    coll_cond = multi | (bus_p & bus_n);
  end

  // Delay pipeline shift and collision edge/counter next values
  always_comb begin
    pipe_p_d    = pipe_p_q;
    pipe_n_d    = pipe_n_q;
    pipe_p_d[0] = bus_p;
    pipe_n_d[0] = bus_n;
    for (int unsigned i = 1; i < DELAY; i++) begin
      pipe_p_d[i] = pipe_p_q[i-1];
      pipe_n_d[i] = pipe_n_q[i-1];
    end
    coll_cond_d = coll_cond;
    collision_d = coll_cond & ~coll_cond_q;
    coll_cnt_d  = coll_cnt_q;
    if (collision_d && (coll_cnt_q != '1)) begin
      coll_cnt_d = coll_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline, collision and counter registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pipe_p_q    <= '0;
      pipe_n_q    <= '0;
      coll_cond_q <= 1'b0;
      collision_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      pipe_p_q    <= pipe_p_d;
      pipe_n_q    <= pipe_n_d;
      coll_cond_q <= coll_cond_d;
      collision_q <= collision_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

`ifdef MIL_BUS_HUB_FAULT_INJECT_EN
  logic swap_q, swap_d;

  // Swap request is registered so the corrupted cycle follows the pulse
  always_comb begin
    swap_d = faultEn & faultSwap;
  end

  // Swap request register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) swap_q <= 1'b0;
    else       swap_q <= swap_d;
  end

  assign rx_bit_p = swap_q ? pipe_n_q[DELAY-1] : pipe_p_q[DELAY-1];
  assign rx_bit_n = swap_q ? pipe_p_q[DELAY-1] : pipe_n_q[DELAY-1];
`else
  assign rx_bit_p = pipe_p_q[DELAY-1];
  assign rx_bit_n = pipe_n_q[DELAY-1];
`endif

  assign rxP       = {PORTS{rx_bit_p}};
  assign rxN       = {PORTS{rx_bit_n}};
  assign collision = collision_q;
  assign collCnt   = coll_cnt_q;

endmodule

// File: tb/tb_mil_bus_hub.sv
// tb_mil_bus_hub: scoreboard bench for mil_bus_hub (PORTS=4, DELAY=2,
// BABBLE_MAX=100, IDLE_REL=64, CNT_W=4).
module tb_mil_bus_hub;

  localparam int unsigned PORTS = 4;
  localparam int unsigned DELAY = 2;
  localparam int unsigned BMAX  = 100;
  localparam int unsigned IREL  = 64;
  localparam int unsigned CW    = 4;

  logic             clk = 1'b0;
  logic             nRst;
  logic [PORTS-1:0] txP, txN, portEn, babbleClr;
  logic [PORTS-1:0] rxP, rxN, babble;
  logic             collision;
  logic [CW-1:0]    collCnt;
`ifdef MIL_BUS_HUB_FAULT_INJECT_EN
  logic             faultEn, faultSwap;
`endif

  mil_bus_hub #(
    .PORTS      (PORTS),
    .DELAY      (DELAY),
    .BABBLE_MAX (BMAX),
    .IDLE_REL   (IREL),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .txP       (txP),
    .txN       (txN),
    .portEn    (portEn),
    .babbleClr (babbleClr),
`ifdef MIL_BUS_HUB_FAULT_INJECT_EN
    .faultEn   (faultEn),
    .faultSwap (faultSwap),
`endif
    .rxP       (rxP),
    .rxN       (rxN),
    .babble    (babble),
    .collision (collision),
    .collCnt   (collCnt)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_iso[PORTS];
  int unsigned m_run[PORTS];
  int unsigned m_idle[PORTS];
  bit          m_cond, m_coll, m_swap;
  int unsigned m_cnt;
  logic [1:0]  rx_q[$];   // expected {rxP, rxN} bit per cycle

  // last observed outputs
  logic [PORTS-1:0] obs_rxp, obs_rxn, obs_babble;
  logic             obs_coll;
  logic [CW-1:0]    obs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PORTS; i++) begin
      m_iso[i]  = 1'b0;
      m_run[i]  = 0;
      m_idle[i] = 0;
    end
    m_cond = 1'b0;
    m_coll = 1'b0;
    m_swap = 1'b0;
    m_cnt  = 0;
    rx_q.delete();
    for (int i = 0; i < DELAY; i++) rx_q.push_back(2'b00);
  endtask

  // One clock cycle: compare outputs against the model at negedge, advance the
  // model with the current inputs, then move to just after the next posedge.
  task automatic step();
    logic [1:0]       exp_rx;
    logic [PORTS-1:0] act, exp_b;
    logic             bp, bn, busy;
    bit               cond;
    int unsigned      nact;
    @(negedge clk);
    exp_rx = rx_q.pop_front();
    if (m_swap) exp_rx = {exp_rx[0], exp_rx[1]};
    for (int i = 0; i < PORTS; i++) exp_b[i] = m_iso[i];
    check_eq("rxP", 32'(rxP), 32'({PORTS{exp_rx[1]}}));
    check_eq("rxN", 32'(rxN), 32'({PORTS{exp_rx[0]}}));
    check_eq("babble", 32'(babble), 32'(exp_b));
    check_eq("collision", 32'(collision), 32'(m_coll));
    check_eq("collCnt", 32'(collCnt), 32'(m_cnt));
    obs_rxp = rxP; obs_rxn = rxN; obs_babble = babble;
    obs_coll = collision; obs_cnt = collCnt;

    nact = 0; bp = 1'b0; bn = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      act[i] = (txP[i] | txN[i]) & portEn[i] & ~m_iso[i];
      if (act[i]) begin
        nact++;
        bp = bp | txP[i];
        bn = bn | txN[i];
      end
    end
    rx_q.push_back({bp, bn});
    cond = (nact >= 2) || (bp && bn);
    m_coll = cond && !m_cond;
    if (m_coll && m_cnt != (1 << CW) - 1) m_cnt++;
    m_cond = cond;
`ifdef MIL_BUS_HUB_FAULT_INJECT_EN
    m_swap = faultEn & faultSwap;
`endif
    for (int i = 0; i < PORTS; i++) begin
      busy = txP[i] | txN[i];
      if (!portEn[i]) begin
        m_iso[i] = 1'b0; m_run[i] = 0; m_idle[i] = 0;
      end else if (m_iso[i]) begin
        if (babbleClr[i]) begin
          m_iso[i] = 1'b0; m_idle[i] = 0;
        end else if (!busy) begin
          m_idle[i]++;
          if (m_idle[i] == IREL) begin m_iso[i] = 1'b0; m_idle[i] = 0; end
        end else m_idle[i] = 0;
      end else if (act[i]) begin
        m_run[i]++;
        if (m_run[i] == BMAX) begin m_iso[i] = 1'b1; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first, cnt;
    nRst = 1'b1; txP = '0; txN = '0; portEn = '1; babbleClr = '0;
`ifdef MIL_BUS_HUB_FAULT_INJECT_EN
    faultEn = 1'b0; faultSwap = 1'b0;
`endif
    model_reset();
    #2 nRst = 1'b0;
    #1;
    check_eq("rst_rx", 32'({rxP, rxN}), 0);
    check_eq("rst_babble", 32'(babble), 0);
    check_eq("rst_coll", 32'(collision), 0);
    check_eq("rst_cnt", 32'(collCnt), 0);
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;

    // single talker on port0: rx high for exactly 10 cycles starting at cycle 2
    first = -1; cnt = 0;
    for (int k = 0; k < 14; k++) begin
      txP = (k < 10) ? 4'b0001 : 4'b0000;
      step();
      if (obs_rxp == 4'hF) begin cnt++; if (first < 0) first = k; end
      if (obs_coll) cnt += 100;
    end
    check_eq("t1_first", 32'(first), 2);
    check_eq("t1_count", 32'(cnt), 10);

    // ports 1 and 2 together, three bursts: one pulse each
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
        txP = (k < 5) ? 4'b0110 : 4'b0000;
        step();
        if (obs_coll) cnt++;
      end
      check_eq("t2_pulses", 32'(cnt), 1);
    end
    check_eq("t2_cnt", 32'(obs_cnt), 3);

    // port3 babbles: isolated at cycle 100, bus clear 2 cycles later
    first = -1; cnt = -1;
    for (int k = 0; k < 150; k++) begin
      txP = 4'b1000;
      step();
      if (obs_babble[3] && first < 0) first = k;
      if (k >= 100 && obs_rxp == 4'h0 && cnt < 0) cnt = k;
    end
    check_eq("t3_iso", 32'(first), 100);
    check_eq("t3_rx0", 32'(cnt), 102);
    first = -1;
    for (int k = 0; k < 70; k++) begin
      txP = 4'b0000;
      step();
      if (!obs_babble[3] && first < 0) first = k;
    end
    check_eq("t3_rel", 32'(first), 64);

    // port2 isolated, manual release while still driving, re-isolation
    for (int k = 0; k < 105; k++) begin
      txP = 4'b0100;
      step();
    end
    check_eq("t4_iso", 32'(obs_babble[2]), 1);
    babbleClr = 4'b0100;
    step();
    babbleClr = 4'b0000;
    first = -1;
    for (int j = 1; j <= 110; j++) begin
      step();
      if (j == 1) check_eq("t4_clr", 32'(obs_babble[2]), 0);
      if (obs_babble[2] && first < 0) first = j;
    end
    check_eq("t4_reiso", 32'(first), 101);
    portEn = 4'b1011; txP = 4'b0000;
    step();
    portEn = 4'b1111;
    step();
    check_eq("t4_en_clr", 32'(obs_babble[2]), 0);

    // twenty more collisions: counter saturates
    cnt = 0;
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) begin
        txP = (k < 2) ? 4'b0011 : 4'b0000;
        step();
        if (obs_coll) cnt++;
      end
    end
    step();
    check_eq("t5_pulses", 32'(cnt), 20);
    check_eq("t5_sat", 32'(obs_cnt), 32'hF);

    // mid-frame reset with isolated port and full pipeline
    for (int k = 0; k < 101; k++) begin
      txP = 4'b1000;
      step();
    end
    for (int k = 0; k < 5; k++) begin
      txP = 4'b1001;
      step();
    end
    check_eq("t6_pre_rx", 32'(obs_rxp), 32'hF);
    check_eq("t6_pre_bab", 32'(obs_babble), 32'h8);
    #2 nRst = 1'b0;
    #1;
    check_eq("t6_rx", 32'({rxP, rxN}), 0);
    check_eq("t6_babble", 32'(babble), 0);
    check_eq("t6_cnt", 32'(collCnt), 0);
    check_eq("t6_coll", 32'(collision), 0);
    txP = '0;
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) step();

`ifdef MIL_BUS_HUB_FAULT_INJECT_EN
    // one faultSwap pulse during a port0 transmission
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      txP = (k < 10) ? 4'b0001 : 4'b0000;
      faultEn = (k >= 3);
      faultSwap = (k == 4);
      step();
      if (obs_rxp == 4'h0 && obs_rxn == 4'hF) cnt++;
    end
    faultEn = 1'b0;
    check_eq("t7_swap", 32'(cnt), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
